// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
// Used by uart_rx and uart_tx_top so both ends agree on frame shape and idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int   DATA_BITS        = 8;
  localparam logic IDLE_LEVEL       = 1'b1;
  localparam int   BAUD_DIV_DEFAULT = 10416;  // 100 MHz / 9600 baud

  // 2-of-3 vote used when bits are decided from three neighbouring samples
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector comparing the synced level against its one-cycle-delayed copy.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_sync,
  output logic fall_pulse
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // All three flops come out of reset at the idle level so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= IDLE_LEVEL;
      sync_reg <= IDLE_LEVEL;
      prev_reg <= IDLE_LEVEL;
    end else begin
      meta_reg <= rx_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign rx_sync    = sync_reg;
  assign fall_pulse = prev_reg & ~sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling with a BAUD_DIV-cycle bit timer.
// Optional build macro UART_RX_MAJORITY_EN: decide each bit by a 2-of-3 vote around the midpoint.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_DIV_DEFAULT,
  parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(BAUD_DIV);

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_LAG = 1;
`else
  localparam int SAMPLE_LAG = 0;
`endif

  // With voting, every decision slips one cycle so the midpoint+1 sample exists;
  // data/stop decisions keep the same offset because they count from the start decision.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(BAUD_DIV / 2 - 1 + SAMPLE_LAG);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       LAST_IDX   = 3'(DATA_BITS - 1);

  logic rx_sync;
  logic fall_pulse;
  logic bit_val;

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .rx_sync    (rx_sync),
    .fall_pulse (fall_pulse)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg <= {2{IDLE_LEVEL}};
    end else begin
      hist_reg <= {hist_reg[0], rx_sync};
    end
  end

  assign bit_val = majority3(rx_sync, hist_reg[0], hist_reg[1]);
`else
  assign bit_val = rx_sync;
`endif

  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 rx_busy_reg;
  logic                 data_sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      baud_cnt_reg  <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      rx_busy_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
      rx_busy_reg   <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next     = state_reg;
    baud_cnt_next  = baud_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    data_sample    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rx_en && fall_pulse) begin
          state_next    = START;
          baud_cnt_next = '0;
        end
      end

      START: begin
        if (baud_cnt_reg == START_LAST) begin
          baud_cnt_next = '0;
          if (bit_val == IDLE_LEVEL) begin
            state_next = IDLE;  // line went back high: glitch, not a start bit
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (baud_cnt_reg == BIT_LAST) begin
          baud_cnt_next = '0;
          data_sample   = 1'b1;
          if (bit_idx_reg == LAST_IDX) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      STOP: begin
        if (baud_cnt_reg == BIT_LAST) begin
          baud_cnt_next = '0;
          if (bit_val == IDLE_LEVEL) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
            state_next    = IDLE;  // leave at mid-stop so a back-to-back start is caught
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_HIGH;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      WAIT_HIGH: begin
        // A held-low line (break) must not look like a fresh start edge
        if (rx_sync == IDLE_LEVEL) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
    assign shift_next[gi] = (data_sample && (bit_idx_reg == 3'(gi))) ? bit_val : shift_reg[gi];
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign rx_busy   = rx_busy_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at BAUD_DIV=16; expected bytes come
// from a queue model of "every frame with a high stop bit delivers its byte".
module tb_uart_rx;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (rx_en),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         n_ferr    = 0;
  int         valid_cyc = 0;
  int         frame_cyc = 0;
  bit         busy_seen = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] last_good;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (rx_valid) begin
        got_q.push_back(rx_data);
        valid_cyc = cyc;
        check("busy_falls_with_valid", {30'd0, prev_busy, rx_busy}, 32'b10);
      end
      if (frame_err) n_ferr++;
      if (rx_valid || frame_err) check("valid_ferr_exclusive", {31'd0, rx_valid & frame_err}, 0);
      if (rx_busy) busy_seen = 1'b1;
      prev_busy = rx_busy;
    end
  end

  // bits[0] is the start bit, bits[9] the stop bit; glitch inverts each data-bit midpoint cycle
  task automatic drive_bits(input logic [9:0] bits, input int ncyc, input bit glitch);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) frame_cyc = cyc;
      rx_in = bits[c / BD] ^ (glitch && (c / BD) >= 1 && (c / BD) <= 8 && (c % BD) == BD / 2);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit glitch);
    drive_bits({stop_ok, b, 1'b0}, 10 * BD, glitch);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  task automatic expect_good(input logic [7:0] b);
    exp_q.push_back(b);
    last_good = b;
  endtask

  task automatic phase_check(input string tag, input int exp_ferr);
    int n;
    check({tag, "_frames"}, got_q.size(), exp_q.size());
    check({tag, "_frame_errs"}, n_ferr, exp_ferr);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
    $display("phase %s: %0d bytes, %0d frame errors", tag, got_q.size(), n_ferr);
    got_q.delete();
    exp_q.delete();
    n_ferr = 0;
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    logic [7:0] glitch_exp;

    rst   = 1'b1;
    rx_en = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_busy", rx_busy, 0);
    check("reset_frame_err", frame_err, 0);
    rst = 1'b0;
    idle(10);

    // Single good frame
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("a5_rx_data", rx_data, 8'hA5);
    check("a5_latency_in_window",
          {31'd0, ((valid_cyc - frame_cyc) >= 150) && ((valid_cyc - frame_cyc) <= 160)}, 1);
    phase_check("single_a5", 0);

    // Back-to-back frames, no idle gap
    expect_good(8'h00);
    send_frame(8'h00, 1'b1, 1'b0);
    expect_good(8'hFF);
    send_frame(8'hFF, 1'b1, 1'b0);
    expect_good(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    check("b2b_rx_data", rx_data, 8'h3C);
    phase_check("back_to_back", 0);

    // Bad stop bit followed by a held-low line
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (3 * BD) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    check("break_busy_held", rx_busy, 1);
    check("break_no_valid", got_q.size(), 0);
    idle(10);
    check("break_released_idle", rx_busy, 0);
    check("break_rx_data_kept", rx_data, 8'h3C);
    expect_good(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    check("after_break_rx_data", rx_data, 8'h81);
    phase_check("stop_error", 1);

    // Two-cycle low glitch on an idle line
    busy_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    idle(40);
    check("glitch_start_entered", {31'd0, busy_seen}, 1);
    check("glitch_back_idle", rx_busy, 0);
    check("glitch_rx_data_kept", rx_data, 8'h81);
    phase_check("start_glitch", 0);

    // Reset in the middle of data bit 4 of 0xC3
    drive_bits({1'b1, 8'hC3, 1'b0}, 5 * BD + BD / 2, 1'b0);
    @(negedge clk);
    rst   = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    check("midrst_busy", rx_busy, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_ferr", frame_err, 0);
    rst = 1'b0;
    idle(40);
    check("midrst_stays_idle", rx_busy, 0);
    phase_check("mid_reset_quiet", 0);
    expect_good(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(20);
    phase_check("after_reset", 0);

    // Single-cycle inversion at every data-bit midpoint
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h0F;
`else
    glitch_exp = 8'hF0;
`endif
    expect_good(glitch_exp);
    send_frame(8'h0F, 1'b1, 1'b1);
    idle(20);
    check("midpoint_glitch_rx_data", rx_data, glitch_exp);
    phase_check("midpoint_glitch", 0);

    // Receiver disabled: starts ignored
    rx_en     = 1'b0;
    busy_seen = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0);
    idle(20);
    check("disabled_never_busy", {31'd0, busy_seen}, 0);
    phase_check("disabled", 0);
    rx_en = 1'b1;

    // Randomized frames with occasional bad stop bits and random gaps
    begin
      int exp_ferr = 0;
      for (int i = 0; i < 24; i++) begin
        b  = 8'($urandom);
        ok = ($urandom_range(0, 9) != 0);
        if (ok) expect_good(b);
        else    exp_ferr++;
        send_frame(b, ok, 1'b0);
        idle(ok ? int'($urandom_range(0, 12)) : int'($urandom_range(8, 20)));
      end
      idle(20);
      check("random_final_rx_data", rx_data, last_good);
      phase_check("random", exp_ferr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
